// File: rtl/iob_vga_sync.sv
// iob_vga_sync: 640x480@60 Hz raster timing generator and registered VGA output stage.
// Scans the frame, hands (x,y) to the image memory, registers the returned colour
// together with hsync/vsync, and emits a one-clk frame-start pulse for tick pacing.
// Optional build macro VGA_TEST_PATTERN_EN adds input vga_tp_sel, which substitutes
// eight vertical colour bars for the image memory colour in the active area.
module iob_vga_sync #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        vga_tp_sel,
`endif
    output logic [9:0]  vga_pixel_x,
    output logic [9:0]  vga_pixel_y,
    input  logic [11:0] vga_rgb_in,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [11:0] vga_rgb,
    output logic        vga_video_on,
    output logic        vga_frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Counters are 10 bits wide, so neither total may exceed 1024.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("iob_vga_sync: H_TOTAL and V_TOTAL must both be <= 1024");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("iob_vga_sync: CLK_DIV must be >= 1");
        end
    endgenerate

    logic [9:0]  h_cnt_reg;
    logic [9:0]  v_cnt_reg;
    logic        tick;
    logic        h_wrap;
    logic        v_wrap;
    logic        hs_raw;
    logic        vs_raw;
    logic        video_on;
    logic [11:0] pix_src;
    logic        hs_reg;
    logic        vs_reg;
    logic [11:0] rgb_reg;

    // Pixel-rate enable; with CLK_DIV=1 every clock is a pixel.
    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign tick = 1'b1;
        end else begin : g_div
            logic [DIV_W-1:0] div_cnt_reg;

            // Free-running clock divider, restarted by reset.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    div_cnt_reg <= '0;
                end else if (div_cnt_reg == DIV_W'(CLK_DIV - 1)) begin
                    div_cnt_reg <= '0;
                end else begin
                    div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                end
            end

            assign tick = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
        end
    endgenerate

    assign h_wrap = (h_cnt_reg == 10'(H_TOTAL - 1));
    assign v_wrap = (v_cnt_reg == 10'(V_TOTAL - 1));

    // Raster position: h advances every tick, v advances when h wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (tick) begin
            if (h_wrap) begin
                h_cnt_reg <= '0;
                v_cnt_reg <= v_wrap ? 10'd0 : v_cnt_reg + 10'd1;
            end else begin
                h_cnt_reg <= h_cnt_reg + 10'd1;
            end
        end
    end

    // Compare in 11 bits so a sync window ending exactly at 1024 still decodes.
    assign video_on = ({1'b0, h_cnt_reg} < 11'(H_ACTIVE)) && ({1'b0, v_cnt_reg} < 11'(V_ACTIVE));
    assign hs_raw   = ({1'b0, h_cnt_reg} >= 11'(HS_START)) && ({1'b0, h_cnt_reg} < 11'(HS_END));
    assign vs_raw   = ({1'b0, v_cnt_reg} >= 11'(VS_START)) && ({1'b0, v_cnt_reg} < 11'(VS_END));

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    generate
        if (BAR_W < 1) begin : g_bad_bar
            $error("iob_vga_sync: H_ACTIVE must be >= 8 for the test pattern");
        end
    endgenerate

    // Bar colours: R on for bars 0,1,4,5; G on for 0..3; B on for even bars.
    logic [11:0] bar_lut [8];
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bar
            localparam logic [2:0] IDX = 3'(gi);
            assign bar_lut[gi] = {{4{~IDX[1]}}, {4{~IDX[2]}}, {4{~IDX[0]}}};
        end
    endgenerate

    logic [9:0] bar_q;
    logic [2:0] bar_idx;

    // Pick the bar under the current column, clamping any remainder columns to bar 7.
    always_comb begin
        bar_q   = h_cnt_reg / 10'(BAR_W);
        bar_idx = (bar_q > 10'd7) ? 3'd7 : bar_q[2:0];
        pix_src = vga_tp_sel ? bar_lut[bar_idx] : vga_rgb_in;
    end
`else
    assign pix_src = vga_rgb_in;
`endif

    // Output stage: sync and colour registered together so they stay aligned.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hs_reg  <= ~SYNC_POL;
            vs_reg  <= ~SYNC_POL;
            rgb_reg <= 12'h000;
        end else if (tick) begin
            hs_reg  <= hs_raw ? SYNC_POL : ~SYNC_POL;
            vs_reg  <= vs_raw ? SYNC_POL : ~SYNC_POL;
            rgb_reg <= video_on ? pix_src : 12'h000;
        end
    end

    assign vga_pixel_x     = h_cnt_reg;
    assign vga_pixel_y     = v_cnt_reg;
    assign vga_video_on    = video_on;
    assign vga_hs          = hs_reg;
    assign vga_vs          = vs_reg;
    assign vga_rgb         = rgb_reg;
    // Gated by rst so a reset cycle never reports a frame boundary.
    assign vga_frame_start = rst & tick & h_wrap & v_wrap;

endmodule

// File: tb/tb_iob_vga_sync.sv
// Testbench for iob_vga_sync using a shrunken raster so whole frames fit in a short run.
// A cycle-count model predicts coordinates; registered outputs go through a scoreboard queue.
module tb_iob_vga_sync;

    localparam int D  = 2;
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 25
    localparam int VT = VA + VF + VS + VB;   // 11
    localparam bit POL = 1'b0;
    localparam int FRAME = HT * VT * D;      // 550 clks

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  vga_pixel_x;
    logic [9:0]  vga_pixel_y;
    logic [11:0] vga_rgb_in;
    logic        vga_hs;
    logic        vga_vs;
    logic [11:0] vga_rgb;
    logic        vga_video_on;
    logic        vga_frame_start;
`ifdef VGA_TEST_PATTERN_EN
    logic        vga_tp_sel;
`endif

    always #5 clk = ~clk;

    iob_vga_sync #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
        .vga_tp_sel(vga_tp_sel),
`endif
        .vga_pixel_x(vga_pixel_x),
        .vga_pixel_y(vga_pixel_y),
        .vga_rgb_in(vga_rgb_in),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_rgb(vga_rgb),
        .vga_video_on(vga_video_on),
        .vga_frame_start(vga_frame_start)
    );

    int checks = 0;
    int failures = 0;

    // Colour sources: 0 = constant ABC, 1 = constant FFF, 2 = image function of (x,y)
    int   cur_mode = 1;
    logic tp_cur = 1'b0;
    logic nxt_rst = 1'b0;
    int   nxt_mode = 1;
    logic nxt_tp = 1'b0;

    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    function automatic logic [11:0] img(input int x, input int y);
        return 12'(x * 53 + y * 197 + 12'h1C3);
    endfunction

    function automatic logic [11:0] src(input int m, input int x, input int y);
        if (m == 0) return 12'hABC;
        if (m == 1) return 12'hFFF;
        return img(x, y);
    endfunction

    // Image memory: colour is a combinational function of the DUT's coordinates.
    always_comb begin
        vga_rgb_in = src(cur_mode, int'(vga_pixel_x), int'(vga_pixel_y));
    end

    function automatic logic [13:0] expect_out(input int h, input int v, input int m, input logic tp);
        logic        hs_e, vs_e;
        logic [11:0] rgb_e;
        hs_e = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
        vs_e = (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
        rgb_e = 12'h000;
        if (h < HA && v < VA) rgb_e = tp ? bars[h / (HA / 8)] : src(m, h, v);
        return {hs_e, vs_e, rgb_e};
    endfunction

    // Model and scoreboard state
    int          cyc = 0;        // rising edges with rst high since the last reset edge
    bit          model_valid = 0;
    logic [13:0] exp_q [$];
    logic [13:0] out_exp;
    int          mh = 0, mv = 0;
    int          gcyc = 0;
    logic        prev_hs = 1'bx, prev_vs = 1'bx;
    int          hs_fall = -1, hs_width = -1, hs_period = -1;
    int          vs_fall = -1, vs_width = -1, vs_period = -1;
    int          fs_count = 0;

    // One clock: compare state at negedge, then apply next inputs and advance the model.
    task automatic step();
        int          p;
        bit          tk;
        bit          fs_e;
        bit          von_e;
        logic [13:0] got;
        @(negedge clk);
        gcyc++;
        if (exp_q.size() > 0) out_exp = exp_q.pop_front();
        p  = cyc / D;
        mh = p % HT;
        mv = (p / HT) % VT;
        tk = ((cyc % D) == D - 1);
        if (model_valid) begin
            von_e = (mh < HA) && (mv < VA);
            fs_e  = (rst === 1'b1) && tk && (mh == HT - 1) && (mv == VT - 1);
            got   = {vga_hs, vga_vs, vga_rgb};
            checks++;
            if (vga_pixel_x !== 10'(mh)) begin
                failures++;
                $display("FAIL pixel_x t=%0d got=%0d exp=%0d", gcyc, vga_pixel_x, mh);
            end
            checks++;
            if (vga_pixel_y !== 10'(mv)) begin
                failures++;
                $display("FAIL pixel_y t=%0d got=%0d exp=%0d", gcyc, vga_pixel_y, mv);
            end
            checks++;
            if (vga_video_on !== von_e) begin
                failures++;
                $display("FAIL video_on t=%0d got=%b exp=%b", gcyc, vga_video_on, von_e);
            end
            checks++;
            if (vga_frame_start !== fs_e) begin
                failures++;
                $display("FAIL frame_start t=%0d got=%b exp=%b", gcyc, vga_frame_start, fs_e);
            end
            checks++;
            if (got !== out_exp) begin
                failures++;
                $display("FAIL outputs t=%0d got hs=%b vs=%b rgb=%h exp hs=%b vs=%b rgb=%h",
                         gcyc, got[13], got[12], got[11:0], out_exp[13], out_exp[12], out_exp[11:0]);
            end
            if (prev_hs === 1'b1 && vga_hs === 1'b0) begin
                if (hs_fall >= 0) hs_period = gcyc - hs_fall;
                hs_fall = gcyc;
            end
            if (prev_hs === 1'b0 && vga_hs === 1'b1 && hs_fall >= 0) hs_width = gcyc - hs_fall;
            if (prev_vs === 1'b1 && vga_vs === 1'b0) begin
                if (vs_fall >= 0) vs_period = gcyc - vs_fall;
                vs_fall = gcyc;
            end
            if (prev_vs === 1'b0 && vga_vs === 1'b1 && vs_fall >= 0) vs_width = gcyc - vs_fall;
            if (vga_frame_start === 1'b1) fs_count++;
        end
        prev_hs = vga_hs;
        prev_vs = vga_vs;
        rst      = nxt_rst;
        cur_mode = nxt_mode;
        tp_cur   = nxt_tp;
`ifdef VGA_TEST_PATTERN_EN
        vga_tp_sel = nxt_tp;
`endif
        if (!nxt_rst) begin
            cyc = 0;
            exp_q.delete();
            out_exp = {~POL, ~POL, 12'h000};
            model_valid = 1;
        end else begin
            if (tk) exp_q.push_back(expect_out(mh, mv, nxt_mode, nxt_tp));
            cyc++;
        end
    endtask

    task automatic clear_meas();
        hs_fall = -1; hs_width = -1; hs_period = -1;
        vs_fall = -1; vs_width = -1; vs_period = -1;
        fs_count = 0;
    endtask

    task automatic test_reset();
        nxt_rst = 1'b0; nxt_mode = 1; nxt_tp = 1'b0;
        repeat (5) step();
        checks++;
        if ({vga_hs, vga_vs} !== 2'b11) begin
            failures++;
            $display("FAIL reset_sync got=%b%b exp=11", vga_hs, vga_vs);
        end
        checks++;
        if (vga_rgb !== 12'h000) begin
            failures++;
            $display("FAIL reset_rgb got=%h exp=000", vga_rgb);
        end
        checks++;
        if (vga_pixel_x !== 10'd0 || vga_pixel_y !== 10'd0 || vga_frame_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_coords got x=%0d y=%0d fs=%b exp 0 0 0", vga_pixel_x, vga_pixel_y, vga_frame_start);
        end
        nxt_rst = 1'b1;
        repeat (D) step();
        checks++;
        if (vga_pixel_x !== 10'd0) begin
            failures++;
            $display("FAIL first_tick_early got=%0d exp=0", vga_pixel_x);
        end
        step();
        checks++;
        if (vga_pixel_x !== 10'd1) begin
            failures++;
            $display("FAIL first_tick got=%0d exp=1", vga_pixel_x);
        end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_line_timing();
        nxt_mode = 2;
        clear_meas();
        repeat (3 * HT * D) step();
        checks++;
        if (hs_width != HS * D) begin
            failures++;
            $display("FAIL hs_width got=%0d exp=%0d", hs_width, HS * D);
        end
        checks++;
        if (hs_period != HT * D) begin
            failures++;
            $display("FAIL hs_period got=%0d exp=%0d", hs_period, HT * D);
        end
        $display("test_line_timing hs_width=%0d hs_period=%0d", hs_width, hs_period);
    endtask

    task automatic test_frame_timing();
        nxt_mode = 2;
        clear_meas();
        repeat (2 * FRAME) step();
        checks++;
        if (fs_count != 2) begin
            failures++;
            $display("FAIL frame_start_count got=%0d exp=2", fs_count);
        end
        checks++;
        if (vs_width != VS * HT * D) begin
            failures++;
            $display("FAIL vs_width got=%0d exp=%0d", vs_width, VS * HT * D);
        end
        checks++;
        if (vs_period != FRAME) begin
            failures++;
            $display("FAIL vs_period got=%0d exp=%0d", vs_period, FRAME);
        end
        $display("test_frame_timing fs=%0d vs_width=%0d vs_period=%0d", fs_count, vs_width, vs_period);
    endtask

    task automatic test_blanking();
        int nz;
        nz = 0;
        nxt_mode = 0;
        repeat (FRAME) begin
            step();
            if (vga_rgb !== 12'h000) nz++;
        end
        checks++;
        if (nz != HA * VA * D) begin
            failures++;
            $display("FAIL blank_count got=%0d exp=%0d", nz, HA * VA * D);
        end
        $display("test_blanking coloured_clks=%0d", nz);
    endtask

    task automatic test_reset_mid_frame();
        nxt_mode = 2;
        for (int i = 0; i < FRAME + 10; i++) begin
            step();
            if (mv == VA / 2 && mh == HT / 3) break;
        end
        checks++;
        if (!(mv == VA / 2 && mh == HT / 3)) begin
            failures++;
            $display("FAIL midframe_reach got v=%0d h=%0d exp v=%0d h=%0d", mv, mh, VA / 2, HT / 3);
        end
        nxt_rst = 1'b0;
        step();
        nxt_rst = 1'b1;
        fs_count = 0;
        step();
        checks++;
        if (vga_pixel_x !== 10'd0 || vga_pixel_y !== 10'd0 || vga_hs !== ~POL || vga_vs !== ~POL || vga_rgb !== 12'h000) begin
            failures++;
            $display("FAIL midframe_reset got x=%0d y=%0d hs=%b vs=%b rgb=%h exp 0 0 1 1 000",
                     vga_pixel_x, vga_pixel_y, vga_hs, vga_vs, vga_rgb);
        end
        repeat (FRAME - 2) step();
        checks++;
        if (fs_count != 0) begin
            failures++;
            $display("FAIL midframe_no_fs got=%0d exp=0", fs_count);
        end
        step();
        checks++;
        if (fs_count != 1) begin
            failures++;
            $display("FAIL midframe_fs got=%0d exp=1", fs_count);
        end
        $display("test_reset_mid_frame fs_after_frame=%0d", fs_count);
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        nxt_mode = 2;
        nxt_tp = 1'b1;
        repeat (FRAME) step();
        nxt_tp = 1'b0;
        repeat (2 * HT * D) step();
        $display("test_pattern done checks=%0d failures=%0d", checks, failures);
    endtask
`endif

    initial begin
        rst = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        vga_tp_sel = 1'b0;
`endif
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_blanking();
        test_reset_mid_frame();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
